// File: rtl/ccla_pipe_adder_if.sv
// Operand/result handshake bundle for ccla_pipe_adder.
// The op_sub field exists only when ADDSUB_MODE_EN is defined.
interface ccla_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADDSUB_MODE_EN
    logic             op_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef ADDSUB_MODE_EN
        output op_sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
`ifdef ADDSUB_MODE_EN
        input  op_sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/ccla_pipe_adder.sv
// Pipelined carry-lookahead adder: WIDTH split into STAGES segments, one segment per clock.
// Define ADDSUB_MODE_EN to add the op_sub input (a - b when set).
module ccla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input logic clk,
    input logic rst,
    ccla_pipe_adder_if.slave bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / GROUP;
    localparam int L    = STAGES - 1;

    generate
        if ((STAGES < 1) || (GROUP < 1) || ((WIDTH % (STAGES * GROUP)) != 0)) begin : g_param_check
            $error("ccla_pipe_adder: WIDTH=%0d must be a multiple of STAGES*GROUP=%0d",
                   WIDTH, STAGES * GROUP);
        end
    endgenerate

    // One segment: lookahead inside each GROUP block, block G/P chains the groups.
    // Returns {carry out, carry into segment MSB, sum bits}.
    function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] x,
                                               input logic [SEG-1:0] y,
                                               input logic           c0);
        logic [SEG-1:0] g, p, c;
        logic [NGRP:0]  gc;
        logic           blk_g, blk_p, term, cc;
        // NOTE: blocking assignments are right here; the function is pure combinational scratch.
        g     = x & y;
        p     = x ^ y;
        c     = '0;
        gc    = '0;
        gc[0] = c0;
        for (int j = 0; j < NGRP; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                cc = 1'b0;
                for (int m = 0; m <= i; m++) begin
                    term = (m == 0) ? gc[j] : g[j*GROUP + m - 1];
                    for (int q = m; q < i; q++) term = term & p[j*GROUP + q];
                    cc = cc | term;
                end
                c[j*GROUP + i] = cc;
            end
            blk_g = 1'b0;
            blk_p = 1'b1;
            for (int m = 0; m < GROUP; m++) begin
                term = g[j*GROUP + m];
                for (int q = m + 1; q < GROUP; q++) term = term & p[j*GROUP + q];
                blk_g = blk_g | term;
                blk_p = blk_p & p[j*GROUP + m];
            end
            gc[j+1] = blk_g | (blk_p & gc[j]);
        end
        return {gc[NGRP], c[SEG-1], p ^ c};
    endfunction

    // Stage k: operands, completed lower sum bits, carry into segment k.
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic [SEG+1:0]   res [STAGES];
    logic             load [STAGES+1];

    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef ADDSUB_MODE_EN
    assign b_in = bus.op_sub ? ~bus.b : bus.b;
    assign c_in = bus.op_sub ? 1'b1   : bus.cin;
`else
    assign b_in = bus.b;
    assign c_in = bus.cin;
`endif

    // A stage may load when empty or when its successor is taking its content.
    assign load[STAGES] = bus.out_ready;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            assign load[k] = !v_q[k] || load[k+1];
            assign res[k]  = seg_add(a_q[k][k*SEG +: SEG], b_q[k][k*SEG +: SEG], c_q[k]);

            if (k == 0) begin : g_first
                // NOTE: data registers are reset too, so sum/cout/ovf read zero out of reset.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        v_q[0] <= 1'b0;
                        a_q[0] <= '0;
                        b_q[0] <= '0;
                        s_q[0] <= '0;
                        c_q[0] <= 1'b0;
                    end else if (load[0]) begin
                        v_q[0] <= bus.in_valid;
                        a_q[0] <= bus.a;
                        b_q[0] <= b_in;
                        s_q[0] <= '0;
                        c_q[0] <= c_in;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) begin
                        v_q[k] <= 1'b0;
                        a_q[k] <= '0;
                        b_q[k] <= '0;
                        s_q[k] <= '0;
                        c_q[k] <= 1'b0;
                    end else if (load[k]) begin
                        v_q[k]                    <= v_q[k-1];
                        a_q[k]                    <= a_q[k-1];
                        b_q[k]                    <= b_q[k-1];
                        s_q[k]                    <= s_q[k-1];
                        s_q[k][(k-1)*SEG +: SEG]  <= res[k-1][SEG-1:0];
                        c_q[k]                    <= res[k-1][SEG+1];
                    end
                end
            end
        end
    endgenerate

    // Final segment resolves combinationally from the last stage, so outputs hold while it stalls.
    // NOTE: every output gets a full default first so no latch can be inferred.
    always_comb begin
        bus.sum              = s_q[L];
        bus.sum[L*SEG +: SEG] = res[L][SEG-1:0];
        bus.cout             = res[L][SEG+1];
        bus.ovf              = res[L][SEG] ^ res[L][SEG+1];
        bus.out_valid        = v_q[L];
        bus.in_ready         = load[0];
    end
endmodule

// File: tb/tb_ccla_pipe_adder.sv
// Directed bench for ccla_pipe_adder (WIDTH=32, GROUP=4, STAGES=2).
// Define ADDSUB_MODE_EN for the subtraction vectors as well.
module tb_ccla_pipe_adder;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ccla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    ccla_pipe_adder #(.WIDTH(WIDTH), .GROUP(4), .STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
    endtask

    // Called at a falling edge; one beat in, result expected two edges later.
    task automatic single(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        bus.out_ready = 1'b1;
        drive(1'b1, a, b, c);
        #1;
        chk_bit({tag, " in_ready"}, bus.in_ready, 1'b1);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0);
        #1;
        chk_bit({tag, " early_valid"}, bus.out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk_bit({tag, " out_valid"}, bus.out_valid, 1'b1);
        chk_word({tag, " sum"}, bus.sum, es);
        chk_bit({tag, " cout"}, bus.cout, ec);
        chk_bit({tag, " ovf"}, bus.ovf, eo);
        @(negedge clk);
        #1;
        chk_bit({tag, " drained"}, bus.out_valid, 1'b0);
    endtask

    logic [WIDTH-1:0] sa [8];
    logic [WIDTH-1:0] sb [8];
    logic             sc [8];
    logic [WIDTH:0]   sx [8];

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
`ifdef ADDSUB_MODE_EN
        bus.op_sub = 1'b0;
`endif

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk_bit("reset out_valid", bus.out_valid, 1'b0);
        chk_word("reset sum", bus.sum, '0);
        chk_bit("reset cout", bus.cout, 1'b0);
        chk_bit("reset ovf", bus.ovf, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk_bit("post_reset in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        // Carry across both segments, overflow corners, intra-segment carry.
        single("all_ones_plus1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        single("maxpos_plus1",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single("minneg_twice",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        single("seg_boundary",   32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        single("mixed_cin",      32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);
        single("neg1_neg1_cin",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Eight back-to-back beats; results must appear on consecutive cycles in order.
        for (int i = 0; i < 8; i++) begin
            sa[i] = WIDTH'(i) * 32'h1357_9BDF;
            sb[i] = 32'hF0F0_F0F0 ^ WIDTH'(i * 3);
            sc[i] = (i % 2) == 1;
            sx[i] = {1'b0, sa[i]} + {1'b0, sb[i]} + {{WIDTH{1'b0}}, sc[i]};
        end
        bus.out_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            if (t < 8) drive(1'b1, sa[t], sb[t], sc[t]);
            else       drive(1'b0, '0, '0, 1'b0);
            #1;
            if (t < 8) chk_bit($sformatf("stream%0d in_ready", t), bus.in_ready, 1'b1);
            if (t >= 2) begin
                chk_bit($sformatf("stream%0d out_valid", t - 2), bus.out_valid, 1'b1);
                chk_word($sformatf("stream%0d sum", t - 2), bus.sum, sx[t-2][WIDTH-1:0]);
                chk_bit($sformatf("stream%0d cout", t - 2), bus.cout, sx[t-2][WIDTH]);
            end else begin
                chk_bit($sformatf("stream fill%0d out_valid", t), bus.out_valid, 1'b0);
            end
            @(negedge clk);
        end
        #1;
        chk_bit("stream drained", bus.out_valid, 1'b0);

        // Backpressure: two beats fill the pipe, then in_ready drops and outputs hold.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0);
        #1;
        chk_bit("bp A in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b0);
        #1;
        chk_bit("bp B in_ready", bus.in_ready, 1'b1);
        chk_bit("bp B out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b1);
        for (int h = 0; h < 5; h++) begin
            #1;
            chk_bit($sformatf("bp hold%0d in_ready", h), bus.in_ready, 1'b0);
            chk_bit($sformatf("bp hold%0d out_valid", h), bus.out_valid, 1'b1);
            chk_word($sformatf("bp hold%0d sum", h), bus.sum, 32'h0000_0003);
            chk_bit($sformatf("bp hold%0d cout", h), bus.cout, 1'b0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk_bit("bp release in_ready", bus.in_ready, 1'b1);
        chk_word("bp A sum", bus.sum, 32'h0000_0003);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0);
        #1;
        chk_bit("bp B out_valid", bus.out_valid, 1'b1);
        chk_word("bp B sum", bus.sum, 32'h0000_0000);
        chk_bit("bp B cout", bus.cout, 1'b1);
        @(negedge clk);
        #1;
        chk_bit("bp C out_valid", bus.out_valid, 1'b1);
        chk_word("bp C sum", bus.sum, 32'h0001_0000);
        chk_bit("bp C cout", bus.cout, 1'b0);
        @(negedge clk);
        #1;
        chk_bit("bp drained", bus.out_valid, 1'b0);
        @(negedge clk);

        // Reset with two beats in flight: nothing may emerge afterwards.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h0000_0030, 32'h0000_0040, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0);
        #1;
        chk_bit("midrst inflight out_valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk_bit("midrst out_valid", bus.out_valid, 1'b0);
        chk_word("midrst sum", bus.sum, '0);
        @(negedge clk);
        #1;
        chk_bit("midrst later out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        single("post_midrst", 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0009, 1'b0, 1'b0);

`ifdef ADDSUB_MODE_EN
        bus.op_sub = 1'b1;
        single("sub_3_5",     32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        single("sub_cin_ign", 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        single("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        bus.op_sub = 1'b0;
        single("add_again",   32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
